// File: rtl/bullcow_pkg.sv
// bullcow_pkg
// Shared definitions for the Bulls-and-Cows match engine and the display
// block that consumes its outputs.
//   state_t        : FSM state encoding (3 bits, explicit values)
//   PHASE_*        : phase codes as seen on the engine's phase output
//   cnt_w()        : width needed to hold a count from 0..n inclusive
package bullcow_pkg;

    typedef enum logic [2:0] {
        S_SECRET = 3'd0,
        S_GUESS  = 3'd1,
        S_SCORE  = 3'd2,
        S_RESULT = 3'd3,
        S_WIN    = 3'd4,
        S_LOSE   = 3'd5
    } state_t;

    // The display block decodes these; they mirror the state encoding so
    // the engine can drive phase straight from its state register.
    localparam logic [2:0] PHASE_SECRET = 3'd0;
    localparam logic [2:0] PHASE_GUESS  = 3'd1;
    localparam logic [2:0] PHASE_SCORE  = 3'd2;
    localparam logic [2:0] PHASE_RESULT = 3'd3;
    localparam logic [2:0] PHASE_WIN    = 3'd4;
    localparam logic [2:0] PHASE_LOSE   = 3'd5;

    // Never returns zero so that a degenerate parameter cannot produce an
    // empty vector.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bullcow_code_check.sv
// bullcow_code_check
// Purely combinational validity check for one N-digit code. Also used by the
// display block for live error indication while the player is dialling.
// Ports:
//   code      in  DIGITS*DIGIT_W  digit 0 at the LSBs
//   valid     out 1               every digit < BASE and all digits distinct
//   range_err out 1               at least one digit >= BASE
//   dup_err   out 1               at least two digits are equal
module bullcow_code_check #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4,
    parameter int BASE    = 10
) (
    input  logic [DIGITS*DIGIT_W-1:0] code,
    output logic                      valid,
    output logic                      range_err,
    output logic                      dup_err
);

    // One extra bit so BASE == 2**DIGIT_W is representable and the range
    // check then correctly never fires.
    localparam logic [DIGIT_W:0] BASE_V = (DIGIT_W + 1)'(BASE);

    logic [DIGITS-1:0][DIGIT_W-1:0] digit;

    assign digit = code;

    always_comb begin
        range_err = 1'b0;
        dup_err   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ({1'b0, digit[i]} >= BASE_V) begin
                range_err = 1'b1;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            for (int j = i + 1; j < DIGITS; j++) begin
                if (digit[i] == digit[j]) begin
                    dup_err = 1'b1;
                end
            end
        end
        valid = !range_err && !dup_err;
    end

endmodule

// File: rtl/bullcow_match_engine.sv
// bullcow_match_engine
// Bulls-and-Cows game core: latches a secret, accepts guesses, scores each
// guess one digit per cycle and tracks tries until win (or lose).
// Optional feature macro: BULLCOW_ATTEMPT_LIMIT_EN
//   defined   -> lose after MAX_TRIES non-winning guesses (S_LOSE)
//   undefined -> unlimited guesses, lose tied low, tries saturates
// Ports:
//   clock        in  1              system clock
//   reset        in  1              asynchronous, active-low
//   enter        in  1              one-cycle debounced pulse
//   code_in      in  DIGITS*DIGIT_W digit 0 at the LSBs
//   bulls/cows   out cnt_w(DIGITS)  score of the last guess
//   result_valid out 1              one-cycle pulse when bulls/cows update
//   tries        out cnt_w(MAX_TRIES) valid guesses scored
//   code_err     out 1              rejected entry, held until next enter
//   phase        out 3              current state for the display
//   win / lose   out 1              sticky until reset
module bullcow_match_engine
    import bullcow_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int DIGIT_W   = 4,
    parameter int BASE      = 10,
    parameter int MAX_TRIES = 10
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enter,
    input  logic [DIGITS*DIGIT_W-1:0]     code_in,
    output logic [cnt_w(DIGITS)-1:0]      bulls,
    output logic [cnt_w(DIGITS)-1:0]      cows,
    output logic                          result_valid,
    output logic [cnt_w(MAX_TRIES)-1:0]   tries,
    output logic                          code_err,
    output logic [2:0]                    phase,
    output logic                          win,
    output logic                          lose
);

    localparam int CW = cnt_w(DIGITS);
    localparam int TW = cnt_w(MAX_TRIES);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t state_q, state_d;

    logic [DIGITS-1:0][DIGIT_W-1:0] secret_q;
    logic [DIGITS-1:0][DIGIT_W-1:0] guess_q;
    logic [IW-1:0]                  idx_q;
    logic [CW-1:0]                  bull_acc;
    logic [CW-1:0]                  cow_acc;

    logic               chk_valid, chk_range, chk_dup;
    logic               code_ok;
    logic [DIGIT_W-1:0] cur_digit;
    logic               is_bull;
    logic               in_secret;
    logic               last_idx;
    logic               is_win;
    logic [TW-1:0]      tries_next;
    logic               limit_hit;

    bullcow_code_check #(
        .DIGITS  (DIGITS),
        .DIGIT_W (DIGIT_W),
        .BASE    (BASE)
    ) u_check (
        .code      (code_in),
        .valid     (chk_valid),
        .range_err (chk_range),
        .dup_err   (chk_dup)
    );

    // valid already implies both flags are clear; all three are folded in so
    // the checker's full interface is consumed here as it is by the display.
    assign code_ok = chk_valid && !chk_range && !chk_dup;

    assign phase = state_q;

    // Digit under scrutiny this cycle and whether it is a bull or a cow.
    // Codes are duplicate-free, so each guess digit matches at most one
    // secret digit and bulls+cows can never exceed DIGITS.
    always_comb begin
        cur_digit = guess_q[idx_q];
        is_bull   = (cur_digit == secret_q[idx_q]);
        in_secret = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (secret_q[j] == cur_digit) begin
                in_secret = 1'b1;
            end
        end
    end

    assign last_idx   = (idx_q == IW'(DIGITS - 1));
    assign is_win     = (bull_acc == CW'(DIGITS));
    assign tries_next = (tries == {TW{1'b1}}) ? tries : tries + 1'b1;

`ifdef BULLCOW_ATTEMPT_LIMIT_EN
    assign limit_hit = (tries_next == TW'(MAX_TRIES));
`else
    assign limit_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_SECRET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Enter is only honoured in S_SECRET and S_GUESS; in
    // every other state it is dropped rather than queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SECRET: if (enter && code_ok) state_d = S_GUESS;
            S_GUESS:  if (enter && code_ok) state_d = S_SCORE;
            S_SCORE:  if (last_idx)         state_d = S_RESULT;
            S_RESULT: begin
                if (is_win) begin
                    state_d = S_WIN;
                end else if (limit_hit) begin
                    state_d = S_LOSE;
                end else begin
                    state_d = S_GUESS;
                end
            end
            S_WIN:    state_d = S_WIN;
            S_LOSE:   state_d = S_LOSE;
            default:  state_d = S_SECRET;
        endcase
    end

    // Datapath: code latching, the per-digit scorer and the registered
    // outputs. Outputs are written on the S_RESULT cycle, so they appear
    // together with the state that follows it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            secret_q     <= '0;
            guess_q      <= '0;
            idx_q        <= '0;
            bull_acc     <= '0;
            cow_acc      <= '0;
            bulls        <= '0;
            cows         <= '0;
            result_valid <= 1'b0;
            tries        <= '0;
            code_err     <= 1'b0;
            win          <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state_q)
                S_SECRET: begin
                    if (enter) begin
                        code_err <= !code_ok;
                        if (code_ok) begin
                            secret_q <= code_in;
                        end
                    end
                end
                S_GUESS: begin
                    if (enter) begin
                        code_err <= !code_ok;
                        if (code_ok) begin
                            guess_q  <= code_in;
                            bull_acc <= '0;
                            cow_acc  <= '0;
                            idx_q    <= '0;
                        end
                    end
                end
                S_SCORE: begin
                    if (is_bull) begin
                        bull_acc <= bull_acc + 1'b1;
                    end else if (in_secret) begin
                        cow_acc <= cow_acc + 1'b1;
                    end
                    idx_q <= last_idx ? '0 : idx_q + 1'b1;
                end
                S_RESULT: begin
                    bulls        <= bull_acc;
                    cows         <= cow_acc;
                    result_valid <= 1'b1;
                    tries        <= tries_next;
                    if (is_win) begin
                        win <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef BULLCOW_ATTEMPT_LIMIT_EN
    // Sticky lose flag, raised on the final non-winning result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lose <= 1'b0;
        end else if (state_q == S_RESULT && !is_win && limit_hit) begin
            lose <= 1'b1;
        end
    end
`else
    assign lose = 1'b0;
`endif

endmodule

// File: tb/tb_bullcow_match_engine.sv
// tb_bullcow_match_engine
// Directed bench for bullcow_match_engine with DIGITS=4, BASE=10, hex-nibble
// codes and MAX_TRIES=3. Honours BULLCOW_ATTEMPT_LIMIT_EN for the limit test.
module tb_bullcow_match_engine;
    import bullcow_pkg::*;

    localparam int DIGITS    = 4;
    localparam int DIGIT_W   = 4;
    localparam int BASE      = 10;
    localparam int MAX_TRIES = 3;
    localparam int CW        = cnt_w(DIGITS);
    localparam int TW        = cnt_w(MAX_TRIES);

    logic                      clock = 1'b0;
    logic                      reset = 1'b0;
    logic                      enter = 1'b0;
    logic [DIGITS*DIGIT_W-1:0] code_in = '0;
    logic [CW-1:0]             bulls;
    logic [CW-1:0]             cows;
    logic                      result_valid;
    logic [TW-1:0]             tries;
    logic                      code_err;
    logic [2:0]                phase;
    logic                      win;
    logic                      lose;

    int total = 0;
    int bad   = 0;

    bullcow_match_engine #(
        .DIGITS    (DIGITS),
        .DIGIT_W   (DIGIT_W),
        .BASE      (BASE),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enter        (enter),
        .code_in      (code_in),
        .bulls        (bulls),
        .cows         (cows),
        .result_valid (result_valid),
        .tries        (tries),
        .code_err     (code_err),
        .phase        (phase),
        .win          (win),
        .lose         (lose)
    );

    always #5 clock = ~clock;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        enter   = 1'b0;
        code_in = '0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic pulse(input logic [15:0] code);
        code_in = code;
        enter   = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    // Cycles from the sampling edge of enter until result_valid; capped.
    task automatic wait_result(output int cyc);
        cyc = 0;
        while (result_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (phase !== PHASE_SECRET) begin bad++; $display("[TB] FAIL reset_phase: got %0d want %0d", phase, PHASE_SECRET); end
        total++; if ({bulls, cows, tries, result_valid, code_err, win, lose} !== '0) begin bad++;
            $display("[TB] FAIL reset_outputs: got b=%0d c=%0d t=%0d rv=%0d err=%0d w=%0d l=%0d want all 0", bulls, cows, tries, result_valid, code_err, win, lose); end
    endtask

    task automatic test_score();
        int cyc;
        do_reset();
        pulse(16'h1234);
        total++; if (phase !== PHASE_GUESS) begin bad++; $display("[TB] FAIL secret_accept_phase: got %0d want %0d", phase, PHASE_GUESS); end
        pulse(16'h1243);
        total++; if (phase !== PHASE_SCORE) begin bad++; $display("[TB] FAIL score_phase: got %0d want %0d", phase, PHASE_SCORE); end
        wait_result(cyc);
        total++; if (cyc !== 5) begin bad++; $display("[TB] FAIL score_latency: got %0d want 5", cyc); end
        total++; if (bulls !== 2 || cows !== 2) begin bad++; $display("[TB] FAIL score_1243: got b=%0d c=%0d want b=2 c=2", bulls, cows); end
        total++; if (tries !== 1 || phase !== PHASE_GUESS) begin bad++; $display("[TB] FAIL score_tries_phase: got t=%0d p=%0d want t=1 p=%0d", tries, phase, PHASE_GUESS); end
        tick();
        total++; if (result_valid !== 1'b0) begin bad++; $display("[TB] FAIL rv_single_cycle: got %0d want 0", result_valid); end
        // Secret 1234 vs guess 4321: no bulls, four cows.
        pulse(16'h4321);
        wait_result(cyc);
        total++; if (bulls !== 0 || cows !== 4 || tries !== 2) begin bad++; $display("[TB] FAIL score_4321: got b=%0d c=%0d t=%0d want b=0 c=4 t=2", bulls, cows, tries); end
        // Secret 1234 vs guess 1590: one bull, no cows.
        pulse(16'h1590);
        wait_result(cyc);
        total++; if (bulls !== 1 || cows !== 0) begin bad++; $display("[TB] FAIL score_1590: got b=%0d c=%0d want b=1 c=0", bulls, cows); end
    endtask

    task automatic test_win();
        int cyc;
        int nres;
        do_reset();
        pulse(16'h1234);
        pulse(16'h1234);
        wait_result(cyc);
        total++; if (bulls !== 4 || cows !== 0 || win !== 1'b1) begin bad++; $display("[TB] FAIL win_score: got b=%0d c=%0d w=%0d want b=4 c=0 w=1", bulls, cows, win); end
        total++; if (phase !== PHASE_WIN) begin bad++; $display("[TB] FAIL win_phase: got %0d want %0d", phase, PHASE_WIN); end
        nres = 0;
        pulse(16'h5678);
        repeat (10) begin
            tick();
            if (result_valid === 1'b1) nres++;
        end
        total++; if (nres !== 0 || bulls !== 4 || tries !== 1 || phase !== PHASE_WIN || win !== 1'b1) begin bad++;
            $display("[TB] FAIL win_terminal: got rv=%0d b=%0d t=%0d p=%0d w=%0d want rv=0 b=4 t=1 p=%0d w=1", nres, bulls, tries, phase, win, PHASE_WIN); end
    endtask

    task automatic test_code_err();
        int cyc;
        do_reset();
        pulse(16'h1123);
        total++; if (code_err !== 1'b1 || phase !== PHASE_SECRET) begin bad++; $display("[TB] FAIL dup_reject: got err=%0d p=%0d want err=1 p=0", code_err, phase); end
        pulse(16'h12A4);
        total++; if (code_err !== 1'b1 || phase !== PHASE_SECRET) begin bad++; $display("[TB] FAIL range_reject: got err=%0d p=%0d want err=1 p=0", code_err, phase); end
        repeat (3) tick();
        total++; if (code_err !== 1'b1) begin bad++; $display("[TB] FAIL err_held: got %0d want 1", code_err); end
        pulse(16'h5678);
        total++; if (code_err !== 1'b0 || phase !== PHASE_GUESS) begin bad++; $display("[TB] FAIL secret_accept: got err=%0d p=%0d want err=0 p=%0d", code_err, phase, PHASE_GUESS); end
        pulse(16'h9999);
        total++; if (code_err !== 1'b1 || phase !== PHASE_GUESS || tries !== 0) begin bad++; $display("[TB] FAIL guess_reject: got err=%0d p=%0d t=%0d want err=1 p=1 t=0", code_err, phase, tries); end
        // Guess 8765 against secret 5678: all four digits are cows.
        pulse(16'h8765);
        total++; if (code_err !== 1'b0) begin bad++; $display("[TB] FAIL guess_accept_err: got %0d want 0", code_err); end
        wait_result(cyc);
        total++; if (bulls !== 0 || cows !== 4 || tries !== 1) begin bad++; $display("[TB] FAIL guess_after_err: got b=%0d c=%0d t=%0d want b=0 c=4 t=1", bulls, cows, tries); end
    endtask

    task automatic test_back_to_back();
        int nres;
        do_reset();
        pulse(16'h1234);
        nres = 0;
        pulse(16'h5678);
        tick();
        if (result_valid === 1'b1) nres++;
        code_in = 16'h1243;
        enter   = 1'b1;
        tick();
        enter = 1'b0;
        if (result_valid === 1'b1) nres++;
        repeat (12) begin
            tick();
            if (result_valid === 1'b1) nres++;
        end
        total++; if (nres !== 1) begin bad++; $display("[TB] FAIL b2b_count: got %0d results want 1", nres); end
        total++; if (bulls !== 0 || cows !== 0 || tries !== 1 || phase !== PHASE_GUESS) begin bad++;
            $display("[TB] FAIL b2b_score: got b=%0d c=%0d t=%0d p=%0d want b=0 c=0 t=1 p=%0d", bulls, cows, tries, phase, PHASE_GUESS); end
    endtask

    task automatic test_limit();
        int cyc;
        int nres;
        do_reset();
        pulse(16'h1234);
        repeat (3) begin
            pulse(16'h5678);
            wait_result(cyc);
        end
`ifdef BULLCOW_ATTEMPT_LIMIT_EN
        total++; if (lose !== 1'b1 || phase !== PHASE_LOSE || tries !== 3) begin bad++;
            $display("[TB] FAIL limit_lose: got l=%0d p=%0d t=%0d want l=1 p=%0d t=3", lose, phase, tries, PHASE_LOSE); end
        nres = 0;
        pulse(16'h5678);
        repeat (10) begin
            tick();
            if (result_valid === 1'b1) nres++;
        end
        total++; if (nres !== 0 || phase !== PHASE_LOSE || tries !== 3 || lose !== 1'b1) begin bad++;
            $display("[TB] FAIL lose_terminal: got rv=%0d p=%0d t=%0d l=%0d want rv=0 p=%0d t=3 l=1", nres, phase, tries, lose, PHASE_LOSE); end
`else
        total++; if (lose !== 1'b0 || phase !== PHASE_GUESS || tries !== 3) begin bad++;
            $display("[TB] FAIL nolimit_third: got l=%0d p=%0d t=%0d want l=0 p=%0d t=3", lose, phase, tries, PHASE_GUESS); end
        nres = 0;
        pulse(16'h5678);
        wait_result(cyc);
        if (result_valid === 1'b1) nres++;
        total++; if (nres !== 1 || tries !== 3 || lose !== 1'b0 || phase !== PHASE_GUESS) begin bad++;
            $display("[TB] FAIL tries_saturate: got rv=%0d t=%0d l=%0d p=%0d want rv=1 t=3 l=0 p=%0d", nres, tries, lose, phase, PHASE_GUESS); end
`endif
    endtask

    task automatic test_reset_mid_score();
        int cyc;
        do_reset();
        pulse(16'h1234);
        pulse(16'h1243);
        wait_result(cyc);
        pulse(16'h1243);
        tick();
        #2;
        reset = 1'b0;
        #1;
        total++; if (phase !== PHASE_SECRET) begin bad++; $display("[TB] FAIL midreset_phase: got %0d want %0d", phase, PHASE_SECRET); end
        total++; if ({bulls, cows, tries, result_valid, code_err, win, lose} !== '0) begin bad++;
            $display("[TB] FAIL midreset_outputs: got b=%0d c=%0d t=%0d rv=%0d err=%0d w=%0d l=%0d want all 0", bulls, cows, tries, result_valid, code_err, win, lose); end
        tick();
        reset = 1'b1;
        tick();
        // After reset the engine must want a new secret, not score a guess.
        pulse(16'h1234);
        total++; if (phase !== PHASE_GUESS || tries !== 0) begin bad++; $display("[TB] FAIL postreset_secret: got p=%0d t=%0d want p=%0d t=0", phase, tries, PHASE_GUESS); end
    endtask

    initial begin
        $display("[TB] starting bullcow_match_engine bench");
        test_reset();
        test_score();
        test_win();
        test_code_err();
        test_back_to_back();
        test_limit();
        test_reset_mid_score();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
